// File: rtl/div_if.sv
`default_nettype none
// ---------------------------------------------------------------
// div_if : start/operand/result bundle for the HI/LO divider
// Rev 1.0
// ---------------------------------------------------------------
interface div_if #(
  parameter int WIDTH = 32
);
  logic             div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] low;
  logic             div_end;
  logic             div_zero;

  modport master (
    output div, a, b,
    input  high, low, div_end, div_zero
  );

  modport slave (
    input  div, a, b,
    output high, low, div_end, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ---------------------------------------------------------------
// div : sequential signed restoring divider, LO=quotient HI=remainder
// Rev 1.0
// ---------------------------------------------------------------
module div #(
  parameter int WIDTH = 32
) (
  input  wire   clk,
  input  wire   reset,
  div_if.slave  bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_zero = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;
  localparam int         c_cw      = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [c_cw-1:0]  r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divs;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_low;
  logic             r_div_end;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [2*WIDTH:0] w_rq;
  logic [WIDTH:0]   w_trial;
  logic             w_bit;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  // Magnitudes are unsigned, so the most negative value maps onto itself
  assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  assign w_rq     = {r_rem, r_quo} << 1;
  assign w_trial  = w_rq[2*WIDTH:WIDTH] - {1'b0, r_divs};
  assign w_bit    = ~w_trial[WIDTH];
  assign w_rem_nx = w_bit ? w_trial : w_rq[2*WIDTH:WIDTH];
  assign w_quo_nx = w_rq[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divs     <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_high     <= '0;
      r_low      <= '0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (bus.div) begin
      // A start in any state, BUSY included, abandons the running division
      r_divs     <= w_abs_b;
      r_quo      <= w_abs_a;
      r_rem      <= '0;
      r_cnt      <= c_cw'(WIDTH);
      r_sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_sign_r   <= bus.a[WIDTH-1];
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      r_state    <= (bus.b == '0) ? c_st_zero : c_st_busy;
    end else begin
      case (r_state)
        c_st_busy: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cw'(1)) begin
            r_low     <= r_sign_q ? -w_quo_nx : w_quo_nx;
            r_high    <= r_sign_r ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];
            r_div_end <= 1'b1;
            r_state   <= c_st_done;
          end
        end
        c_st_zero: begin
          // Re-signing the latched magnitude reproduces the original dividend
          r_high     <= r_sign_r ? -r_quo : r_quo;
          r_low      <= '1;
          r_div_zero <= 1'b1;
          r_div_end  <= 1'b1;
          r_state    <= c_st_done;
        end
        default: ;
      endcase
    end
  end

  assign bus.high     = r_high;
  assign bus.low      = r_low;
  assign bus.div_end  = r_div_end;
  assign bus.div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_div : vector table, corner sequences and random signed division
// Rev 1.0
// ---------------------------------------------------------------
module tb_div;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns half a cycle after the start edge
  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    bus.div = 1'b1;
    bus.a   = aa;
    bus.b   = bb;
    @(negedge clk);
    bus.div = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.div_end === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] lo, input logic [31:0] hi, input logic z);
    int lat;
    start_op(aa, bb);
    chk({tag, " end_cleared"}, {31'd0, bus.div_end}, 32'd0);
    chk({tag, " zero_cleared"}, {31'd0, bus.div_zero}, 32'd0);
    wait_done(lat);
    chk({tag, " latency"}, lat, z ? 32'd1 : 32'd32);
    chk({tag, " low"}, bus.low, lo);
    chk({tag, " high"}, bus.high, hi);
    chk({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, z});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = $urandom_range(0, 255);
      6: v = -$urandom_range(0, 255);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          lat;
    logic [31:0] ra, rb, elo, ehi;
    longint      sa, sb;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.div  = 1'b0;
    bus.a    = '0;
    bus.b    = '0;

    tbl[0] = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    tbl[1] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tbl[2] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tbl[3] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    tbl[4] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[5] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0};
    tbl[6] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    tbl[7] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    tbl[8] = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst high", bus.high, 32'd0);
    chk("rst low", bus.low, 32'd0);
    chk("rst div_end", {31'd0, bus.div_end}, 32'd0);
    chk("rst div_zero", {31'd0, bus.div_zero}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].z);
      if (i == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          chk("hold low", bus.low, 32'd3);
          chk("hold high", bus.high, 32'd1);
          chk("hold div_end", {31'd0, bus.div_end}, 32'd1);
        end
      end
    end

    // Reset lands on the tenth edge of a running division
    start_op(32'd100, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst high", bus.high, 32'd0);
    chk("midrst low", bus.low, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      chk("midrst no_end", {31'd0, bus.div_end}, 32'd0);
    end

    // Restart on the fifteenth edge with fresh operands
    start_op(32'd100, 32'd7);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      chk("restart no_end", {31'd0, bus.div_end}, 32'd0);
    end
    run_vec("restart", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = pick();
      rb = pick();
      while (rb == 32'd0) rb = pick();
      sa  = longint'($signed(ra));
      sb  = longint'($signed(rb));
      elo = 32'(sa / sb);
      ehi = 32'(sa % sb);
      start_op(ra, rb);
      wait_done(lat);
      chk($sformatf("rnd %h/%h latency", ra, rb), lat, 32'd32);
      chk($sformatf("rnd %h/%h low", ra, rb), bus.low, elo);
      chk($sformatf("rnd %h/%h high", ra, rb), bus.high, ehi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div.md
Name: div

Overview:
- Sequential signed 32-bit integer divider for the CPU's HI/LO unit; the inverse counterpart of the Booth multiplier.
- Takes a start pulse plus dividend/divisor and runs a 32-iteration restoring division on operand magnitudes.
- Returns quotient on low (LO) and remainder on high (HI), with a done flag and a divide-by-zero flag for the control unit.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- div  input  1  start request, sampled each rising edge
- a  input  WIDTH  dividend (two's complement)
- b  input  WIDTH  divisor (two's complement)
- high  output  WIDTH  remainder (HI), registered
- low  output  WIDTH  quotient (LO), registered
- div_end  output  1  done flag, registered
- div_zero  output  1  divide-by-zero flag, registered

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Reset has priority over div. It forces high=0, low=0, div_end=0, div_zero=0, state IDLE, and clears the internal counter and registers.
- States:
  - IDLE -> (div=1) BUSY or ZERO.
  - BUSY -> (counter reaches 0) DONE.
  - ZERO -> DONE after 1 cycle.
  - DONE -> (div=1) BUSY or ZERO; otherwise holds.
- Start (div=1 on an edge, any state including BUSY):
  - Latch |a|, |b|, sign_q = a[MSB]^b[MSB], sign_r = a[MSB].
  - Clear the partial remainder R (WIDTH+1 bits); load the quotient shift register Q = |a|; set counter = WIDTH.
  - Clear div_end and div_zero.
  - Go to ZERO if b==0, else BUSY.
- Restart mid-operation: a new start discards the current work, takes the new operands, and keeps div_end low.
- Magnitudes: |x| is taken as an unsigned WIDTH-bit value, so |0x80000000| = 0x80000000.
- BUSY step, one per edge:
  - Shift {R,Q} left by 1.
  - Compute T = R - |b| at WIDTH+1 bits.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise keep R and set Q[0] = 0.
  - Decrement the counter.
- Completion: on the edge that performs the WIDTH-th step:
  - low = sign_q ? -Q : Q.
  - high = sign_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - div_end = 1. State DONE.
- Latency: div_end rises exactly WIDTH edges after the start edge (32 cycles).
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
- Overflow: 0x80000000 / 0xFFFFFFFF gives low=0x80000000, high=0. No flag is raised.
- ZERO (b==0): on the next edge, high=a, low={WIDTH{1'b1}}, div_zero=1, div_end=1. Latency is 1 cycle.
- DONE hold: high, low, div_end and div_zero hold their values until the next start or reset. high and low change only at completion or reset.
- div held high: each edge restarts the operation, so completion never occurs. The control unit pulses div for exactly 1 cycle.
- Reset mid-BUSY: the operation is aborted, outputs read 0, and no div_end is produced.

Test Plan:
1. a=7, b=2, 1-cycle div pulse -> div_end=1 exactly 32 edges later; low=0x00000003, high=0x00000001, div_zero=0. Outputs hold for 10 further cycles.
2. Sign cases, each with the same 32-cycle latency:
   - a=-7 (0xFFFFFFF9), b=2 -> low=0xFFFFFFFD, high=0xFFFFFFFF.
   - a=7, b=-2 -> low=0xFFFFFFFD, high=0x00000001.
   - a=-7, b=-2 -> low=0x00000003, high=0xFFFFFFFF.
3. Boundaries:
   - a=0x80000000, b=0xFFFFFFFF -> low=0x80000000, high=0.
   - a=0x7FFFFFFF, b=1 -> low=0x7FFFFFFF, high=0.
   - a=3, b=10 -> low=0, high=3.
4. a=5, b=0 -> next edge: div_end=1, div_zero=1, high=0x00000005, low=0xFFFFFFFF. A following 10/3 start clears div_zero and div_end and completes 32 edges later with low=3, high=1.
5. Start 100/7; at edge 10 assert reset for 1 cycle -> high=low=0, div_end stays 0 for 40 cycles. Start 100/7 again; at edge 15 re-pulse div with 9/4 -> div_end exactly 32 edges after the second pulse, low=2, high=1.
6. Random signed operands (including 0, ±1, 0x80000000; b≠0), 1000 vectors -> low/high equal the reference model (C-style truncating / and %) at edge 32.
